// File: rtl/scurve_single_test_pkg.sv
// Shared S-curve definitions: FSM state encoding, result count width and
// the default timing constants of the single-test control block.
package scurve_single_test_pkg;

    localparam int COUNT_W = 16;
    typedef logic [COUNT_W-1:0] count_t;

    // Default injection timing, in Clk cycles
    localparam int DEF_PULSE_PERIOD = 2000;
    localparam int DEF_PULSE_HIGH   = 100;
    localparam int DEF_TRIG_WINDOW  = 400;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INJECT     = 3'd1,
        S_WRITE_CPT  = 3'd2,
        S_WRITE_TRIG = 3'd3,
        S_DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/scurve_single_test_if.sv
// Write port of the downstream S-curve data FIFO.
//
// Handshake: the producer may assert SCurve_Data_fifo_wr_en only in a cycle
// following a rising edge at which SCurve_Data_fifo_full was sampled low;
// each cycle with wr_en=1 transfers exactly one SCurve_Data_fifo_wr_din word.
// There is no separate ready: full=1 is the back-pressure and stalls the
// producer with wr_en held low.
interface scurve_single_test_if;
    import scurve_single_test_pkg::*;

    logic   SCurve_Data_fifo_full;
    count_t SCurve_Data_fifo_wr_din;
    logic   SCurve_Data_fifo_wr_en;

    modport master (
        input  SCurve_Data_fifo_full,
        output SCurve_Data_fifo_wr_din,
        output SCurve_Data_fifo_wr_en
    );

    modport slave (
        output SCurve_Data_fifo_full,
        input  SCurve_Data_fifo_wr_din,
        input  SCurve_Data_fifo_wr_en
    );

endinterface

// File: rtl/scurve_single_test_trigger_edge_sync.sv
// Two-flop synchronizer for the asynchronous Microroc trigger plus a
// rising-edge detector on the synchronized level.
module trigger_edge_sync (
    input  logic Clk,
    input  logic reset_n,
    input  logic Trigger_In,
    output logic Trigger_Edge
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain and one-cycle-delayed copy for edge detection
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= Trigger_In;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign Trigger_Edge = sync2_q & ~prev_q;

endmodule

// File: rtl/scurve_single_test.sv
// Single S-curve point: fire CPT_Max charge injections, count the periods
// in which the Microroc triggered inside the acceptance window, then write
// the injection count and the trigger count to the data FIFO.
module scurve_single_test
    import scurve_single_test_pkg::*;
#(
    parameter int PULSE_PERIOD = DEF_PULSE_PERIOD,
    parameter int PULSE_HIGH   = DEF_PULSE_HIGH,
    parameter int TRIG_WINDOW  = DEF_TRIG_WINDOW
) (
    input  logic                        Clk,
    input  logic                        reset_n,
    input  logic                        Single_Test_Start,
    input  count_t                      CPT_Max,
    input  logic                        Trigger_In,
    output logic                        Charge_Inject,
    output logic                        Single_Test_Done,
    scurve_single_test_if.master        fifo,
    output state_t                      State_Dbg
);

    // Index wide enough to hold PULSE_PERIOD itself, so TRIG_WINDOW may
    // equal the period without truncation.
    localparam int IDX_W = $clog2(PULSE_PERIOD + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PULSE_PERIOD - 1);
    localparam logic [IDX_W-1:0] HIGH_LIM = IDX_W'(PULSE_HIGH);
    localparam logic [IDX_W-1:0] WIN_LIM  = IDX_W'(TRIG_WINDOW);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    count_t           cpt_q;
    count_t           pulse_cnt_q;
    count_t           trig_cnt_q;
    logic             hit_q;
    logic             charge_q;
    logic             wr_en_q;
    count_t           wr_din_q;
    logic             done_q;

    logic             trig_edge;
    logic             hit_d;
    logic [IDX_W-1:0] idx_d;
    count_t           pulse_cnt_d;

    trigger_edge_sync u_trig_sync (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .Trigger_In   (Trigger_In),
        .Trigger_Edge (trig_edge)
    );

    // Hit for the current period including an edge arriving this very cycle;
    // the flag is sticky so a second edge in one period is not counted again.
    assign hit_d       = hit_q | (trig_edge & (idx_q < WIN_LIM));
    assign idx_d       = idx_q + IDX_W'(1);
    assign pulse_cnt_d = pulse_cnt_q + count_t'(1);

    // Control FSM with registered injection, FIFO and done outputs
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cpt_q       <= '0;
            pulse_cnt_q <= '0;
            trig_cnt_q  <= '0;
            hit_q       <= 1'b0;
            charge_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_din_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    charge_q <= 1'b0;
                    if (Single_Test_Start) begin
                        cpt_q       <= CPT_Max;
                        idx_q       <= '0;
                        pulse_cnt_q <= '0;
                        trig_cnt_q  <= '0;
                        hit_q       <= 1'b0;
                        if (CPT_Max == '0) begin
                            state_q <= S_WRITE_CPT;
                        end else begin
                            state_q  <= S_INJECT;
                            charge_q <= 1'b1;  // index 0 is always inside the pulse
                        end
                    end
                end
                S_INJECT: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        trig_cnt_q  <= trig_cnt_q + count_t'(hit_d);
                        pulse_cnt_q <= pulse_cnt_d;
                        hit_q       <= 1'b0;
                        if (pulse_cnt_d == cpt_q) begin
                            state_q  <= S_WRITE_CPT;
                            charge_q <= 1'b0;
                        end else begin
                            charge_q <= 1'b1;
                        end
                    end else begin
                        idx_q    <= idx_d;
                        hit_q    <= hit_d;
                        charge_q <= (idx_d < HIGH_LIM);
                    end
                end
                S_WRITE_CPT: begin
                    charge_q <= 1'b0;
                    if (!fifo.SCurve_Data_fifo_full) begin
                        wr_din_q <= cpt_q;
                        wr_en_q  <= 1'b1;
                        state_q  <= S_WRITE_TRIG;
                    end
                end
                S_WRITE_TRIG: begin
                    charge_q <= 1'b0;
                    if (!fifo.SCurve_Data_fifo_full) begin
                        wr_din_q <= trig_cnt_q;
                        wr_en_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    charge_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    charge_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign Charge_Inject                = charge_q;
    assign Single_Test_Done             = done_q;
    assign fifo.SCurve_Data_fifo_wr_en  = wr_en_q;
    assign fifo.SCurve_Data_fifo_wr_din = wr_din_q;
    assign State_Dbg                    = state_q;

endmodule
